data_memory_responder: RTL and testbench
========================================

# data_memory_responder

Multi-cycle data memory that services the MEM-stage load/store requests issued by the pipeline. It sits on the responder side of the MEM-stage memory interface, opposite the `mem_read`/`mem_write` control bits carried in the EX/MEM register.
- Accepts one request per handshake and performs byte-, half- or word-granular access with sign/zero extension.
- Returns a single-cycle response after a programmable latency.
- Flags misaligned, out-of-range and illegal requests without touching storage.

## Interface
Parameters:
- `ADDR_WIDTH`, 10, word-address bits; storage is 2^ADDR_WIDTH 32-bit words (byte range 0 .. 2^(ADDR_WIDTH+2)-1).
- `LATENCY`, 2, wait cycles in ACCESS before the response; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept; combinational from state, 0 while `reset`=1.
- `req_read`  in  1  load request (`mem_read`).
- `req_write`  in  1  store request (`mem_write`).
- `req_funct3`  in  3  access size and sign, RISC-V load/store funct3 encoding.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; the low bits are used for SB/SH.
- `rsp_valid`  out  1  one-cycle response strobe.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_error`  out  1  qualified by `rsp_valid`; request rejected, storage unchanged.
- `busy`  out  1  high in ACCESS; used by hazard logic to stall the pipeline.

## Operation
State machine:
- IDLE: `req_ready`=1. A handshake (`req_valid`&`req_ready`) captures all request fields, loads the counter with LATENCY-1, and moves to ACCESS.
- ACCESS: `req_ready`=0, `busy`=1. The counter decrements each cycle. On the edge where the counter is 0:
  - the access is performed: the store commits, or the load data is registered;
  - `rsp_*` is registered;
  - the state moves to RESP.
- RESP: `rsp_valid`=1 for exactly this cycle, `req_ready`=1. A handshake here goes directly to ACCESS (back-to-back); otherwise the state returns to IDLE.

Error checks, all evaluated on the captured request. Any hit gives `rsp_error`=1, `rsp_rdata`=0 and no store:
- `req_read` and `req_write` both 1, or both 0.
- Load funct3 not in {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU}.
- Store funct3 not in {000 SB, 001 SH, 010 SW}.
- Misaligned access: half-word with addr[0]=1, or word with addr[1:0]≠0.
- Out of range: addr[31:ADDR_WIDTH+2] ≠ 0.

Data handling:
- Little-endian; the word index is addr[ADDR_WIDTH+1:2].
- Byte lane = addr[1:0]; half-word lane = addr[1].
- Stores write only the selected byte lanes; other bytes of the word are preserved.
- LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.

Output hold and reset:
- `rsp_rdata` and `rsp_error` hold their values until the next response.
- Storage contents are not reset.

## Timing
- Reset values: state IDLE, `rsp_valid`=0, `rsp_rdata`=0, `rsp_error`=0, `busy`=0, counter 0. `req_ready`=1 from the first cycle after `reset` deasserts.
- Latency: a request accepted in cycle N gives `rsp_valid` in cycle N+1+LATENCY.
- Throughput: back-to-back issue via RESP gives one request per LATENCY+1 cycles.
- Handshake rules:
  - Request fields are sampled only on the handshake edge; changes afterwards are ignored.
  - `req_valid` without `req_ready` is not accepted, and there is no queueing.
- Store visibility: a load accepted in the RESP cycle of a store to the same address returns the new data.
- Reset during ACCESS: the request is aborted and an uncommitted store is dropped. Reset during RESP: `rsp_valid` drops in the next cycle, and the store is already committed.
- Counter width: 4 bits.

## Structure
Additions to package `common`:
- `mem_size_type` enum: MEM_B=3'b000, MEM_H=3'b001, MEM_W=3'b010, MEM_BU=3'b100, MEM_HU=3'b101.
- `mem_req_type` packed struct: read, write, funct3, addr, wdata.
- `mem_rsp_type` packed struct: rdata, error.
- `mem_state_type` enum: IDLE, ACCESS, RESP.

Sub-module `mem_lane_align`, combinational:
- From funct3, addr[1:0] and wdata, it produces the 4-bit byte-enable, lane-shifted store data and the misalignment flag.
- From the raw read word it produces the extended load data.
- The FSM, counter, error checks and storage stay in `data_memory_responder`.

## Test plan
Each scenario checks both response value and cycle timing.
- Reset, then SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → rdata 0xDEADBEEF, error 0, `rsp_valid` exactly at cycle N+3 (LATENCY=2).
- SB 0x13 data 0x80 over 0xDEADBEEF → LW 0x10 returns 0x80ADBEEF; LB 0x13 → 0xFFFFFF80; LBU 0x13 → 0x00000080.
- SH 0x12 data 0x1234 → LH 0x12 → 0x00001234; LHU 0x12 → 0x00001234; LW 0x10 → 0x1234BEEF.
- Error cases → each gives error 1, rdata 0, and a following LW of the target word is unchanged:
  - LW 0x11 (misaligned);
  - SH 0x01 (misaligned);
  - LW at addr 1<<(ADDR_WIDTH+2) (out of range);
  - funct3 011 load (illegal);
  - read=write=1 (both set).
- Back-to-back: SW 0x20 data 0x5, with LW 0x20 held valid → LW accepted in the SW RESP cycle and returns 0x5; period LATENCY+1 cycles; `busy` high only in ACCESS.
- Reset asserted mid-ACCESS of SW 0x30 data 0x7 over an old value of 0x1 → no `rsp_valid`; after reset, LW 0x30 returns 0x1.

Source files
------------

// File: rtl/data_memory_responder_pkg.sv
// Shared memory-stage types: access sizes, request/response bundles,
// and responder state encoding.
package common;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_size_type;

    typedef struct packed {
        logic        read;
        logic        write;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_type;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
    } mem_rsp_type;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } mem_state_type;

endpackage

// File: rtl/data_memory_responder_mem_lane_align.sv
// Byte-lane steering for stores and lane select plus extension for loads.
// funct3[2] marks unsigned loads; funct3[1:0] gives the access size.
module mem_lane_align (
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic        misaligned,
    output logic [31:0] rdata_ext
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic        sext;

    always_comb begin
        be         = 4'hf;
        wdata_lane = wdata;
        misaligned = 1'b0;
        rdata_ext  = rword;
        rbyte      = rword[{addr_lo, 3'b000} +: 8];
        rhalf      = addr_lo[1] ? rword[31:16] : rword[15:0];
        sext       = !funct3[2];
        case (funct3[1:0])
            2'b00: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{sext & rbyte[7]}}, rbyte};
            end
            2'b01: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
                rdata_ext  = {{16{sext & rhalf[15]}}, rhalf};
            end
            default: begin
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/data_memory_responder.sv
// MEM-stage data memory: one request per handshake, response after
// LATENCY wait cycles, errors reported without touching storage.
module data_memory_responder
    import common::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy
);

    mem_state_type    state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    mem_req_type      req_q;
    mem_rsp_type      rsp_q;
    logic             rsp_valid_q;

    logic [31:0] mem [2**ADDR_WIDTH];

    logic        hs, fire, err, illegal, range_err, misaligned;
    logic [3:0]  be;
    logic [31:0] wlane, rword, rext;
    logic [ADDR_WIDTH-1:0] widx;

    assign req_ready = !reset && (state != ACCESS);
    assign hs        = req_valid && req_ready;
    assign fire      = (state == ACCESS) && (cnt == '0);
    assign busy      = (state == ACCESS);
    assign widx      = req_q.addr[ADDR_WIDTH+1:2];
    assign rword     = mem[widx];
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_q.rdata;
    assign rsp_error = rsp_q.error;

    mem_lane_align u_align (
        .funct3     (req_q.funct3),
        .addr_lo    (req_q.addr[1:0]),
        .wdata      (req_q.wdata),
        .rword      (rword),
        .be         (be),
        .wdata_lane (wlane),
        .misaligned (misaligned),
        .rdata_ext  (rext)
    );

    always_comb begin
        illegal = 1'b0;
        if (req_q.read == req_q.write)
            illegal = 1'b1;
        else if (req_q.read)
            illegal = !(req_q.funct3 inside {MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU});
        else
            illegal = !(req_q.funct3 inside {MEM_B, MEM_H, MEM_W});
        range_err = |(req_q.addr >> (ADDR_WIDTH + 2));
        err       = illegal || misaligned || range_err;
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (hs) begin
                    state_nx = ACCESS;
                    cnt_nx   = CNT_W'(LATENCY - 1);
                end
            end
            ACCESS: begin
                if (cnt == '0)
                    state_nx = RESP;
                else
                    cnt_nx = cnt - 1'b1;
            end
            RESP: begin
                if (hs) begin
                    state_nx = ACCESS;
                    cnt_nx   = CNT_W'(LATENCY - 1);
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
            req_q       <= '0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            rsp_valid_q <= fire;
            if (hs)
                req_q <= '{req_read, req_write, req_funct3, req_addr, req_wdata};
            if (fire) begin
                rsp_q.error <= err;
                rsp_q.rdata <= (err || !req_q.read) ? 32'h0 : rext;
            end
        end
    end

    // Storage has no reset; a reset on the commit edge drops the store.
    always_ff @(posedge clk) begin
        if (!reset && fire && !err && req_q.write) begin
            for (int i = 0; i < 4; i++)
                if (be[i])
                    mem[widx][8*i +: 8] <= wlane[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder with ADDR_WIDTH=10, LATENCY=2.
module tb_data_memory_responder;

    localparam int AW  = 10;
    localparam int LAT = 2;
    localparam int EXP_LAT = LAT + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_read, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_error, busy;
    logic [31:0] rsp_rdata;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
        logic        e;
        string       nm;
    } vec_t;

    always #5 clk = ~clk;

    data_memory_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_read   (req_read),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error),
        .busy       (busy)
    );

    task automatic scramble();
        req_valid  = 1'b0;
        req_read   = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b011;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = 32'hA5A5_A5A5;
    endtask

    task automatic do_req(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rdata, output logic err,
                          output int lat, output int busy_bad);
        int k;
        req_read   = rd;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        req_valid  = 1'b1;
        k = 0;
        while (!req_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        @(posedge clk); #1;
        scramble();
        lat      = 99;
        busy_bad = 0;
        rdata    = 'x;
        err      = 'x;
        for (int c = 1; c <= 20; c++) begin
            if (rsp_valid) begin
                lat   = c;
                rdata = rsp_rdata;
                err   = rsp_error;
                if (busy) busy_bad++;
                break;
            end
            if (!busy) busy_bad++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        scramble();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0 ||
            rsp_rdata !== 32'h0 || rsp_error !== 1'b0) begin
            failures++;
            $display("FAIL reset_state valid=%b busy=%b ready=%b rdata=%h err=%b expected all 0",
                     rsp_valid, busy, req_ready, rsp_rdata, rsp_error);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b expected=1", req_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        vec_t v[$];
        logic [31:0] rd;
        logic er;
        int lat, bb;
        v.push_back('{1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "sw_10"});
        v.push_back('{1'b0, 1'b1, 3'b010, 32'h00, 32'h11223344, 32'h0, 1'b0, "sw_00"});
        v.push_back('{1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "lw_10"});
        foreach (v[i]) begin
            do_req(v[i].rd, v[i].wr, v[i].f3, v[i].a, v[i].d, rd, er, lat, bb);
            checks++;
            if (rd !== v[i].exp || er !== v[i].e || lat !== EXP_LAT || bb !== 0) begin
                failures++;
                $display("FAIL %s rdata=%h err=%b lat=%0d busy_bad=%0d expected rdata=%h err=%b lat=%0d",
                         v[i].nm, rd, er, lat, bb, v[i].exp, v[i].e, EXP_LAT);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hDEADBEEF || rsp_error !== 1'b0) begin
            failures++;
            $display("FAIL rsp_hold valid=%b rdata=%h err=%b expected valid=0 rdata=deadbeef err=0",
                     rsp_valid, rsp_rdata, rsp_error);
        end
    endtask

    task automatic test_subword();
        vec_t v[$];
        logic [31:0] rd;
        logic er;
        int lat, bb;
        v.push_back('{1'b0, 1'b1, 3'b000, 32'h13, 32'hFFFF_FF80, 32'h0, 1'b0, "sb_13"});
        v.push_back('{1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, "lw_after_sb"});
        v.push_back('{1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, "lb_13"});
        v.push_back('{1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0, "lbu_13"});
        v.push_back('{1'b1, 1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0, "lb_10"});
        v.push_back('{1'b1, 1'b0, 3'b100, 32'h11, 32'h0, 32'h000000BE, 1'b0, "lbu_11"});
        v.push_back('{1'b0, 1'b1, 3'b001, 32'h12, 32'hABCD_1234, 32'h0, 1'b0, "sh_12"});
        v.push_back('{1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 32'h00001234, 1'b0, "lh_12"});
        v.push_back('{1'b1, 1'b0, 3'b101, 32'h12, 32'h0, 32'h00001234, 1'b0, "lhu_12"});
        v.push_back('{1'b1, 1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0, "lh_10"});
        v.push_back('{1'b1, 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, "lhu_10"});
        v.push_back('{1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234BEEF, 1'b0, "lw_after_sh"});
        foreach (v[i]) begin
            do_req(v[i].rd, v[i].wr, v[i].f3, v[i].a, v[i].d, rd, er, lat, bb);
            checks++;
            if (rd !== v[i].exp || er !== v[i].e || lat !== EXP_LAT || bb !== 0) begin
                failures++;
                $display("FAIL %s rdata=%h err=%b lat=%0d busy_bad=%0d expected rdata=%h err=%b lat=%0d",
                         v[i].nm, rd, er, lat, bb, v[i].exp, v[i].e, EXP_LAT);
            end
        end
    endtask

    task automatic test_errors();
        vec_t v[$];
        logic [31:0] rd;
        logic er;
        int lat, bb;
        v.push_back('{1'b1, 1'b0, 3'b010, 32'h11, 32'h0, 32'h0, 1'b1, "lw_misaligned"});
        v.push_back('{1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234BEEF, 1'b0, "lw_10_intact"});
        v.push_back('{1'b0, 1'b1, 3'b001, 32'h01, 32'h0000FFFF, 32'h0, 1'b1, "sh_misaligned"});
        v.push_back('{1'b1, 1'b0, 3'b010, 32'h00, 32'h0, 32'h11223344, 1'b0, "lw_00_intact_a"});
        v.push_back('{1'b1, 1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1, "lw_out_of_range"});
        v.push_back('{1'b0, 1'b1, 3'b010, 32'h1000, 32'h55555555, 32'h0, 1'b1, "sw_out_of_range"});
        v.push_back('{1'b1, 1'b0, 3'b010, 32'h00, 32'h0, 32'h11223344, 1'b0, "lw_00_intact_b"});
        v.push_back('{1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, "load_f3_011"});
        v.push_back('{1'b1, 1'b1, 3'b010, 32'h10, 32'h0, 32'h0, 1'b1, "read_and_write"});
        v.push_back('{1'b0, 1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 1'b1, "neither_rw"});
        v.push_back('{1'b0, 1'b1, 3'b100, 32'h10, 32'h0, 32'h0, 1'b1, "store_f3_100"});
        v.push_back('{1'b0, 1'b1, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1, "sw_misaligned"});
        v.push_back('{1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234BEEF, 1'b0, "lw_10_final"});
        foreach (v[i]) begin
            do_req(v[i].rd, v[i].wr, v[i].f3, v[i].a, v[i].d, rd, er, lat, bb);
            checks++;
            if (rd !== v[i].exp || er !== v[i].e || lat !== EXP_LAT || bb !== 0) begin
                failures++;
                $display("FAIL %s rdata=%h err=%b lat=%0d busy_bad=%0d expected rdata=%h err=%b lat=%0d",
                         v[i].nm, rd, er, lat, bb, v[i].exp, v[i].e, EXP_LAT);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2, bad;
        logic ready_in_resp;
        logic [31:0] rd;
        logic er;
        req_read = 1'b0; req_write = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h20; req_wdata = 32'h5; req_valid = 1'b1;
        @(posedge clk); #1;
        req_read = 1'b1; req_write = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h20; req_wdata = 32'h0;
        t1 = 99; bad = 0; ready_in_resp = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (rsp_valid) begin
                t1 = c;
                ready_in_resp = req_ready;
                if (busy) bad++;
                break;
            end
            if (!busy || req_ready) bad++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        scramble();
        t2 = 99; rd = 'x; er = 'x;
        for (int c = 1; c <= 20; c++) begin
            if (rsp_valid) begin
                t2 = c; rd = rsp_rdata; er = rsp_error;
                if (busy) bad++;
                break;
            end
            if (!busy) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (t1 !== EXP_LAT || ready_in_resp !== 1'b1) begin
            failures++;
            $display("FAIL b2b_sw lat=%0d ready_in_resp=%b expected lat=%0d ready=1",
                     t1, ready_in_resp, EXP_LAT);
        end
        checks++;
        if (t2 !== EXP_LAT || rd !== 32'h5 || er !== 1'b0) begin
            failures++;
            $display("FAIL b2b_lw period=%0d rdata=%h err=%b expected period=%0d rdata=00000005 err=0",
                     t2, rd, er, EXP_LAT);
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL b2b_busy bad_cycles=%0d expected=0", bad);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd;
        logic er;
        int lat, bb, seen;
        logic busy_pre, ready_rst;
        do_req(1'b0, 1'b1, 3'b010, 32'h30, 32'h1, rd, er, lat, bb);
        @(posedge clk); #1;
        req_read = 1'b0; req_write = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h30; req_wdata = 32'h7; req_valid = 1'b1;
        @(posedge clk); #1;
        scramble();
        busy_pre = busy;
        reset = 1'b1;
        @(posedge clk); #1;
        ready_rst = req_ready;
        seen = rsp_valid ? 1 : 0;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        checks++;
        if (busy_pre !== 1'b1 || ready_rst !== 1'b0 || seen !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort busy_pre=%b ready_rst=%b rsp_seen=%0d busy=%b expected 1 0 0 0",
                     busy_pre, ready_rst, seen, busy);
        end
        do_req(1'b1, 1'b0, 3'b010, 32'h30, 32'h0, rd, er, lat, bb);
        checks++;
        if (rd !== 32'h1 || er !== 1'b0 || lat !== EXP_LAT) begin
            failures++;
            $display("FAIL reset_abort_lw rdata=%h err=%b lat=%0d expected rdata=00000001 err=0 lat=%0d",
                     rd, er, lat, EXP_LAT);
        end
    endtask

    task automatic test_reset_in_resp();
        logic [31:0] rd;
        logic er;
        int lat, bb;
        logic v_resp;
        do_req(1'b0, 1'b1, 3'b010, 32'h40, 32'h9, rd, er, lat, bb);
        v_resp = rsp_valid;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (v_resp !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_resp valid_resp=%b valid_after=%b expected 1 0",
                     v_resp, rsp_valid);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        do_req(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, rd, er, lat, bb);
        checks++;
        if (rd !== 32'h9 || er !== 1'b0 || lat !== EXP_LAT) begin
            failures++;
            $display("FAIL reset_in_resp_lw rdata=%h err=%b lat=%0d expected rdata=00000009 err=0 lat=%0d",
                     rd, er, lat, EXP_LAT);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_subword();
        test_errors();
        test_back_to_back();
        test_reset_abort();
        test_reset_in_resp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
